// File: rtl/alu_seq.sv
// alu_seq: multi-cycle execute unit. Logic, arithmetic, compare and branch
// operations resolve in one cycle; shifts iterate one bit per cycle.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (in_ready high only in IDLE)
//   SrcA, SrcB, Operation operands and 4-bit operation code
//   out_valid / out_ready result handshake
//   ALUResult, BrTaken    registered result and branch condition
module alu_seq #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic [3:0]            Operation,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  BrTaken
);

  localparam int unsigned SHW = $clog2(DATA_WIDTH);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_BNE = 4'b1001;
  localparam logic [3:0] OP_BLT = 4'b1010;
  localparam logic [3:0] OP_BGE = 4'b1011;
  localparam logic [3:0] OP_SLT = 4'b1100;

  // Shift kind is the low two opcode bits: 00 SLL, 01 SRL, 11 SRA.
  localparam logic [1:0] KIND_SLL = 2'b00;
  localparam logic [1:0] KIND_SRA = 2'b11;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state, state_next;
  logic [DATA_WIDTH-1:0]   shreg, shreg_next;
  logic [SHW-1:0]          cnt, cnt_next;
  logic [1:0]              kind, kind_next;
  logic [DATA_WIDTH-1:0]   result_next;
  logic                    br_next;

  logic [DATA_WIDTH-1:0]   alu_c;
  logic                    br_c;
  logic                    is_shift_c;
  logic [SHW-1:0]          amt_c;
  logic [DATA_WIDTH-1:0]   shifted_c;

  // Single-cycle datapath evaluated on the request operands.
  always_comb begin
    alu_c = '0;
    br_c  = 1'b0;
    case (Operation)
      OP_AND: alu_c = SrcA & SrcB;
      OP_OR:  alu_c = SrcA | SrcB;
      OP_ADD: alu_c = SrcA + SrcB;
      OP_XOR: alu_c = SrcA ^ SrcB;
      OP_SUB: alu_c = SrcA - SrcB;
      OP_SLT: alu_c = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_BEQ: begin
        br_c  = (SrcA == SrcB);
        alu_c = {{(DATA_WIDTH-1){1'b0}}, br_c};
      end
      OP_BNE: begin
        br_c  = (SrcA != SrcB);
        alu_c = {{(DATA_WIDTH-1){1'b0}}, br_c};
      end
      OP_BLT: begin
        br_c  = ($signed(SrcA) < $signed(SrcB));
        alu_c = {{(DATA_WIDTH-1){1'b0}}, br_c};
      end
      OP_BGE: begin
        br_c  = ($signed(SrcA) >= $signed(SrcB));
        alu_c = {{(DATA_WIDTH-1){1'b0}}, br_c};
      end
      default: begin
        alu_c = '0;
        br_c  = 1'b0;
      end
    endcase
  end

  assign is_shift_c = (Operation == OP_SLL) || (Operation == OP_SRL) || (Operation == OP_SRA);
  assign amt_c      = SrcB[SHW-1:0];

  // One-bit shift step applied to the working register.
  always_comb begin
    case (kind)
      KIND_SLL: shifted_c = {shreg[DATA_WIDTH-2:0], 1'b0};
      KIND_SRA: shifted_c = {shreg[DATA_WIDTH-1], shreg[DATA_WIDTH-1:1]};
      default:  shifted_c = {1'b0, shreg[DATA_WIDTH-1:1]};
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next  = state;
    shreg_next  = shreg;
    cnt_next    = cnt;
    kind_next   = kind;
    result_next = ALUResult;
    br_next     = BrTaken;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (is_shift_c) begin
            kind_next = Operation[1:0];
            br_next   = 1'b0;
            if (amt_c == '0) begin
              result_next = SrcA;
              state_next  = DONE;
            end else begin
              shreg_next = SrcA;
              cnt_next   = amt_c;
              state_next = SHIFT;
            end
          end else begin
            result_next = alu_c;
            br_next     = br_c;
            state_next  = DONE;
          end
        end
      end
      SHIFT: begin
        shreg_next = shifted_c;
        cnt_next   = cnt - SHW'(1);
        // Final step: publish the shifted value directly.
        if (cnt == SHW'(1)) begin
          result_next = shifted_c;
          br_next     = 1'b0;
          state_next  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and registered outputs; handshake flags follow the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      ALUResult <= '0;
      BrTaken   <= 1'b0;
      shreg     <= '0;
      cnt       <= '0;
      kind      <= '0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      ALUResult <= result_next;
      BrTaken   <= br_next;
      shreg     <= shreg_next;
      cnt       <= cnt_next;
      kind      <= kind_next;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq against a behavioural model.
module tb_alu_seq;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] SrcA = '0;
  logic [DW-1:0] SrcB = '0;
  logic [3:0]    Operation = 4'b0000;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] ALUResult;
  logic          BrTaken;

  int checks = 0;
  int errors = 0;

  alu_seq #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Operation (Operation),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .BrTaken   (BrTaken)
  );

  always #5 clk = ~clk;

  // Reference: result, branch flag and latency from the operation definitions.
  function automatic void model(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                output logic [DW-1:0] r, output logic br, output int lat);
    int n;
    n   = int'(b % DW);
    r   = '0;
    br  = 1'b0;
    lat = 1;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0011: r = a ^ b;
      4'b0110: r = a - b;
      4'b0100: begin r = a << n; lat = 1 + n; end
      4'b0101: begin r = a >> n; lat = 1 + n; end
      4'b0111: begin r = DW'($signed(a) >>> n); lat = 1 + n; end
      4'b1100: r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'b1000: br = (a == b);
      4'b1001: br = (a != b);
      4'b1010: br = ($signed(a) < $signed(b));
      4'b1011: br = ($signed(a) >= $signed(b));
      default: begin r = '0; br = 1'b0; end
    endcase
    if (op[3] && op != 4'b1100 && op[2] == 1'b0) r = br ? 1 : 0;
  endfunction

  // Issue one request, check latency/result/flag, then complete the handshake.
  // Called #1 after a rising edge.
  task automatic run_op(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] er;
    logic          eb;
    int            el;
    int            cyc;
    model(op, a, b, er, eb, el);
    cyc = 0;
    while (!in_ready && cyc < 50) begin @(posedge clk); #1; cyc++; end
    Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc <= int'(DW) + 4) begin @(posedge clk); #1; cyc++; end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL timeout op=%b a=%h b=%h: out_valid never rose", op, a, b);
      return;
    end
    checks++;
    if (cyc !== el) begin
      errors++;
      $display("FAIL latency op=%b a=%h b=%h: got %0d expected %0d", op, a, b, cyc, el);
    end
    checks++;
    if (ALUResult !== er) begin
      errors++;
      $display("FAIL result op=%b a=%h b=%h: got %h expected %h", op, a, b, ALUResult, er);
    end
    checks++;
    if (BrTaken !== eb) begin
      errors++;
      $display("FAIL brtaken op=%b a=%h b=%h: got %b expected %b", op, a, b, BrTaken, eb);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL handshake op=%b: in_ready=%b out_valid=%b expected 1/0", op, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || ALUResult !== '0 || BrTaken !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: ov=%b res=%h br=%b ir=%b expected 0/0/0/1",
               out_valid, ALUResult, BrTaken, in_ready);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_op(4'b0010, 32'hFFFF_FFFF, 32'h1);          // ADD wrap
    run_op(4'b1100, 32'hFFFF_FFFE, 32'h3);          // SLT -2 < 3
    run_op(4'b1011, 32'hFFFF_FFFE, 32'h3);          // BGE
    run_op(4'b1010, 32'hFFFF_FFFE, 32'h3);          // BLT
    run_op(4'b1000, 32'h5, 32'h5);                  // BEQ
    run_op(4'b1001, 32'h5, 32'h5);                  // BNE
    run_op(4'b0111, 32'h8000_0000, 32'h0000_001F);  // SRA max
    run_op(4'b0101, 32'h8000_0000, 32'h0000_001F);  // SRL max
    run_op(4'b0100, 32'h1, 32'hFFFF_FFE4);          // SLL by 4
    run_op(4'b0111, 32'hDEAD_BEEF, 32'h0000_0020);  // shift by 0
    run_op(4'b1110, 32'h1234_5678, 32'h1234_5678);  // unused code
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      run_op(4'($urandom_range(0, 15)), $urandom, $urandom);
    end
  endtask

  task automatic test_backpressure();
    logic ok;
    Operation = 4'b0011; SrcA = 32'hF0F0_F0F0; SrcB = 32'hFF00_FF00; in_valid = 1'b1;
    @(posedge clk); #1;
    // A competing request held during DONE must be ignored.
    Operation = 4'b0010; SrcA = 32'h1; SrcB = 32'h1;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || ALUResult !== 32'h0FF0_0FF0) ok = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (!ok || out_valid !== 1'b1 || ALUResult !== 32'h0FF0_0FF0) begin
      errors++;
      $display("FAIL backpressure_hold: ov=%b ir=%b res=%h expected 1/0/0ff00ff0", out_valid, in_ready, ALUResult);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: ir=%b ov=%b expected 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || ALUResult !== 32'h0FF0_0FF0) begin
      errors++;
      $display("FAIL ignored_request: ov=%b res=%h expected 0/0ff00ff0", out_valid, ALUResult);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic stale;
    run_op(4'b0010, 32'h2, 32'h3);   // leaves a nonzero held result
    Operation = 4'b0100; SrcA = 32'h0000_0ABC; SrcB = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || ALUResult !== '0 || BrTaken !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: ov=%b res=%h br=%b ir=%b expected 0/0/0/1",
               out_valid, ALUResult, BrTaken, in_ready);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || ALUResult !== '0) stale = 1'b1;
    end
    checks++;
    if (stale) begin
      errors++;
      $display("FAIL stale_shift: ov=%b res=%h expected 0/0", out_valid, ALUResult);
    end
    run_op(4'b0110, 32'd10, 32'd3);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] er;
    logic          eb;
    int            el;
    logic          ok;
    ok = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      Operation = 4'b0010; SrcA = $urandom; SrcB = $urandom;
      model(Operation, SrcA, SrcB, er, eb, el);
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || ALUResult !== er || in_ready !== 1'b0) ok = 1'b0;
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) ok = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL back_to_back: two-cycle cadence or result broken, last ov=%b res=%h expected %h",
               out_valid, ALUResult, er);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
